register_8: RTL and testbench
=============================

REGISTER_8 -- requirements
Module: register_8

Interface
REQ-001 Parameter: WIDTH, default 8, data width of the stored word, the shared bus and the monitor output.
REQ-002 Port: clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: latch  input  1  load request; when high at a rising clk edge, the register captures BUS.
REQ-005 Port: enable  input  1  output-enable; when high, the register drives its stored value onto BUS.
REQ-006 Port: BUS  inout  WIDTH  shared tri-state system bus; read when latching, driven when enabled.
REQ-007 Port: REG_OUT  output  WIDTH  continuous view of the stored value, independent of enable.

Function
REQ-008 The block SHALL hold one WIDTH-bit storage register, referred to here as the stored value.
REQ-009 On a rising clk edge with rst low and latch high, the stored value SHALL become the value present on BUS at that edge.
REQ-010 On a rising clk edge with rst low and latch low, the stored value SHALL be unchanged.
REQ-011 Load latency SHALL be one edge: REG_OUT shows the captured value immediately after the capturing edge.
REQ-012 REG_OUT SHALL equal the stored value at all times, combinationally from the register, with no gating by enable or latch.
REQ-013 The BUS drive SHALL be combinational: with enable high and latch low, BUS is driven with the stored value in the same cycle, with no clock delay.
REQ-014 With enable low, the block SHALL drive all BUS bits to high impedance.
REQ-015 If latch and enable are both high, the block SHALL NOT drive BUS; BUS is high impedance and the register captures the externally driven BUS value at the edge, with no self-feedback path.
REQ-016 The block SHALL add no bus arbitration; preventing two drivers at once is the system's responsibility.
REQ-017 The block SHALL contain no arithmetic and no wrap-around; the value is stored and reproduced bit-exact.
REQ-018 The block SHALL place no handshake on latch or enable; both are level-sampled each cycle and may toggle every cycle.

Reset
REQ-019 On a rising clk edge with rst high, the stored value SHALL become 0, so REG_OUT = 0.
REQ-020 rst SHALL take priority over latch at the same edge; the BUS value is ignored.
REQ-021 rst SHALL NOT affect the BUS drive directly; BUS follows REQ-013 to REQ-015, so during reset with enable high BUS shows 0 after the reset edge.
REQ-022 Before the first reset edge the stored value is undefined; the bench SHALL apply reset before checking values.
REQ-023 Deasserting rst mid-operation SHALL need no recovery cycles; latch is honored at the next edge.

Verification
REQ-024 Reset, then latch=0, enable=0 -> REG_OUT = 0x00 and BUS = Z on all 8 bits.
REQ-025 BUS driven 0x01, latch=1, enable=0, one rising edge -> REG_OUT = 0x01.
REQ-026 Following cycle: latch=0, external driver released, enable=0, one edge -> REG_OUT holds 0x01 and BUS = Z.
REQ-027 Following cycle: latch=0, enable=1 -> BUS = 0x01 combinationally before the next edge; REG_OUT stays 0x01 across the edge.
REQ-028 Stored 0x01, BUS driven 0xA5, latch=1, enable=1, one edge -> block does not drive BUS and REG_OUT = 0xA5.
REQ-029 Stored 0xA5, rst=1, latch=1, BUS = 0xFF, one edge -> REG_OUT = 0x00; then rst=0, latch=1, one edge -> REG_OUT = 0xFF.

Source files
------------

// File: rtl/register_8.sv
// Bus-attached storage register: captures the shared tri-state bus on latch,
// drives it back when enabled, and always exposes the stored word on REG_OUT.

module register_8_bit (
    input  logic clk,
    input  logic rst,
    input  logic latch,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (latch)
            q <= d;
    end

endmodule

module register_8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             latch,
    input  logic             enable,
    inout  wire  [WIDTH-1:0] BUS,
    output logic [WIDTH-1:0] REG_OUT
);

    logic [WIDTH-1:0] stored;
    logic             drive_en;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            register_8_bit u_bit (
                .clk   (clk),
                .rst   (rst),
                .latch (latch),
                .d     (BUS[i]),
                .q     (stored[i])
            );
        end
    endgenerate

    // Latching wins over driving so the bus is never fed back into itself.
    assign drive_en = enable & ~latch;
    assign BUS      = drive_en ? stored : {WIDTH{1'bz}};
    assign REG_OUT  = stored;

endmodule

// File: tb/tb_register_8.sv
// Scoreboard bench for register_8: expected REG_OUT values are queued as
// stimulus is applied and popped after each capturing edge.

module tb_register_8;

    logic       clk = 1'b0;
    logic       rst, latch, enable;
    logic       drv_en;
    logic [7:0] drv_val;
    logic [7:0] reg_out;
    logic [7:0] model;
    logic [7:0] exp_v;
    logic [7:0] exp_bus;
    wire  [7:0] bus;
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;

    // Undriven bus bits float high so "not driven" reads as all ones.
    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_pu
            pullup (bus[g]);
        end
    endgenerate

    assign bus = drv_en ? drv_val : 8'bz;

    register_8 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .latch   (latch),
        .enable  (enable),
        .BUS     (bus),
        .REG_OUT (reg_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; latch = 1'b0; enable = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
        tick;
        rst = 1'b0;
        exp_q.push_back(8'h00);
        tick;
        exp_v = exp_q.pop_front();
        checks++;
        if (reg_out !== exp_v) begin
            failures++;
            $display("FAIL reset_reg_out: got %h expected %h", reg_out, exp_v);
        end
        checks++;
        if (bus !== 8'hFF) begin
            failures++;
            $display("FAIL reset_bus_z: got %h expected %h", bus, 8'hFF);
        end
        model = 8'h00;
    endtask

    task automatic test_load;
        drv_en = 1'b1; drv_val = 8'h01; latch = 1'b1; enable = 1'b0;
        exp_q.push_back(8'h01);
        tick;
        exp_v = exp_q.pop_front();
        checks++;
        if (reg_out !== exp_v) begin
            failures++;
            $display("FAIL load_01: got %h expected %h", reg_out, exp_v);
        end
    endtask

    task automatic test_hold;
        latch = 1'b0; drv_en = 1'b0; enable = 1'b0;
        exp_q.push_back(8'h01);
        tick;
        exp_v = exp_q.pop_front();
        checks++;
        if (reg_out !== exp_v) begin
            failures++;
            $display("FAIL hold_01: got %h expected %h", reg_out, exp_v);
        end
        checks++;
        if (bus !== 8'hFF) begin
            failures++;
            $display("FAIL hold_bus_z: got %h expected %h", bus, 8'hFF);
        end
    endtask

    task automatic test_drive;
        latch = 1'b0; enable = 1'b1;
        #1;
        checks++;
        if (bus !== 8'h01) begin
            failures++;
            $display("FAIL drive_comb: got %h expected %h", bus, 8'h01);
        end
        exp_q.push_back(8'h01);
        tick;
        exp_v = exp_q.pop_front();
        checks++;
        if (reg_out !== exp_v) begin
            failures++;
            $display("FAIL drive_reg_out: got %h expected %h", reg_out, exp_v);
        end
        checks++;
        if (bus !== 8'h01) begin
            failures++;
            $display("FAIL drive_after_edge: got %h expected %h", bus, 8'h01);
        end
    endtask

    task automatic test_latch_enable;
        latch = 1'b1; enable = 1'b1; drv_en = 1'b0;
        #1;
        checks++;
        if (bus !== 8'hFF) begin
            failures++;
            $display("FAIL le_no_drive: got %h expected %h", bus, 8'hFF);
        end
        drv_val = 8'hA5; drv_en = 1'b1;
        #1;
        checks++;
        if (bus !== 8'hA5) begin
            failures++;
            $display("FAIL le_bus_ext: got %h expected %h", bus, 8'hA5);
        end
        exp_q.push_back(8'hA5);
        tick;
        exp_v = exp_q.pop_front();
        checks++;
        if (reg_out !== exp_v) begin
            failures++;
            $display("FAIL le_capture: got %h expected %h", reg_out, exp_v);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_priority;
        rst = 1'b1; latch = 1'b1; drv_en = 1'b1; drv_val = 8'hFF; enable = 1'b0;
        exp_q.push_back(8'h00);
        tick;
        exp_v = exp_q.pop_front();
        checks++;
        if (reg_out !== exp_v) begin
            failures++;
            $display("FAIL rst_over_latch: got %h expected %h", reg_out, exp_v);
        end
        rst = 1'b0;
        exp_q.push_back(8'hFF);
        tick;
        exp_v = exp_q.pop_front();
        checks++;
        if (reg_out !== exp_v) begin
            failures++;
            $display("FAIL load_after_rst: got %h expected %h", reg_out, exp_v);
        end
        // Reset with enable high: bus shows the cleared value after the edge.
        rst = 1'b1; latch = 1'b0; enable = 1'b1; drv_en = 1'b0;
        exp_q.push_back(8'h00);
        tick;
        exp_v = exp_q.pop_front();
        checks++;
        if (reg_out !== exp_v) begin
            failures++;
            $display("FAIL rst_enable_reg: got %h expected %h", reg_out, exp_v);
        end
        checks++;
        if (bus !== 8'h00) begin
            failures++;
            $display("FAIL rst_enable_bus: got %h expected %h", bus, 8'h00);
        end
        rst = 1'b0; enable = 1'b0;
        model = 8'h00;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 60; i++) begin
            rst     = ($urandom_range(0, 15) == 0);
            latch   = ($urandom_range(0, 1) == 1);
            enable  = ($urandom_range(0, 1) == 1);
            drv_val = 8'($urandom);
            drv_en  = latch | (!enable && ($urandom_range(0, 1) == 1));
            #1;
            exp_bus = (enable && !latch) ? model : (drv_en ? drv_val : 8'hFF);
            checks++;
            if (bus !== exp_bus) begin
                failures++;
                $display("FAIL b2b_bus[%0d]: got %h expected %h", i, bus, exp_bus);
            end
            model = rst ? 8'h00 : (latch ? drv_val : model);
            exp_q.push_back(model);
            tick;
            exp_v = exp_q.pop_front();
            checks++;
            if (reg_out !== exp_v) begin
                failures++;
                $display("FAIL b2b_reg[%0d]: got %h expected %h", i, reg_out, exp_v);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d expected %0d", exp_q.size(), 0);
        end
    endtask

    initial begin
        rst = 1'b0; latch = 1'b0; enable = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
        model = 8'h00;
        test_reset;
        test_load;
        test_hold;
        test_drive;
        test_latch_enable;
        test_reset_priority;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
